// File: rtl/serial_write_buffer_pkg.sv
// rtl/serial_write_buffer_pkg.sv - shared state encodings and counter sizing for serial buffers
package serial_write_buffer_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_WRITE = 2'd1,
        STATE_RESET = 2'd2
    } state_t;

    // Counter must hold every value from 0 up to and including buf_size.
    function automatic int ctr_size(input int buf_size);
        return $clog2(buf_size + 1);
    endfunction

endpackage

// File: rtl/serial_write_buffer.sv
// rtl/serial_write_buffer.sv - parallel-load, MSB-first serial transmit buffer paced by write strobes
module serial_write_buffer
    import serial_write_buffer_pkg::*;
#(
    parameter int   BUF_SIZE   = 8,
    parameter logic IDLE_LEVEL = 1'b1,
    localparam int  CTR_SIZE   = ctr_size(BUF_SIZE)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                write_sig,
    input  logic [BUF_SIZE-1:0] data_in,
    input  logic [CTR_SIZE-1:0] write_count,
    output logic                data_out,
    output logic                done_sig
);

    state_t              state, state_nxt;
    logic [BUF_SIZE-1:0] shreg, shreg_nxt;
    logic [CTR_SIZE-1:0] ctr, ctr_nxt;
    logic                data_nxt;
    logic                done_nxt;

    logic [CTR_SIZE-1:0] cnt;
    logic [CTR_SIZE-1:0] shamt;
    logic [BUF_SIZE-1:0] aligned;

    // Left-align the requested bits so the first one to send sits at the MSB.
    always_comb begin
        cnt     = (write_count > CTR_SIZE'(BUF_SIZE)) ? CTR_SIZE'(BUF_SIZE) : write_count;
        shamt   = CTR_SIZE'(BUF_SIZE) - cnt;
        aligned = data_in << shamt;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= STATE_RESET;
            shreg    <= '0;
            ctr      <= '0;
            data_out <= IDLE_LEVEL;
            done_sig <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            ctr      <= ctr_nxt;
            data_out <= data_nxt;
            done_sig <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        ctr_nxt   = ctr;
        data_nxt  = data_out;
        done_nxt  = done_sig;
        case (state)
            STATE_RESET: begin
                shreg_nxt = '0;
                ctr_nxt   = '0;
                data_nxt  = IDLE_LEVEL;
                done_nxt  = 1'b1;
                state_nxt = STATE_IDLE;
            end
            STATE_IDLE: begin
                data_nxt = IDLE_LEVEL;
                if (start) begin
                    shreg_nxt = aligned;
                    ctr_nxt   = cnt;
                    done_nxt  = 1'b0;
                    data_nxt  = (cnt == '0) ? IDLE_LEVEL : aligned[BUF_SIZE-1];
                    state_nxt = STATE_WRITE;
                end
            end
            STATE_WRITE: begin
                if (ctr == '0) begin
                    done_nxt  = 1'b1;
                    data_nxt  = IDLE_LEVEL;
                    state_nxt = STATE_IDLE;
                end else if (write_sig) begin
                    shreg_nxt = shreg << 1;
                    ctr_nxt   = ctr - CTR_SIZE'(1);
                    data_nxt  = (ctr > CTR_SIZE'(1)) ? shreg[BUF_SIZE-2] : IDLE_LEVEL;
                end
            end
            default: begin
                done_nxt  = 1'b0;
                state_nxt = STATE_RESET;
            end
        endcase
    end

endmodule
